seq_det_prog: RTL and testbench
===============================

# seq_det_prog

Programmable serial pattern detector, the parametrised successor to the fixed "101" detector. It samples one serial bit per qualified clock and matches the last `len` bits against a runtime-loaded pattern of up to `MAX_LEN` bits. Overlapping and non-overlapping detection modes are both supported. It sits between a serial bit source and downstream control logic, and produces a one-cycle match pulse plus an optional saturating match counter.

## Interface
- `MAX_LEN`, default 8: maximum pattern length; legal range 3..16.
- `CNT_W`, default 8: width of `match_count`.
- Local `LEN_W` = `$clog2(MAX_LEN+1)`.

- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `pat_load` input, 1 bit: load new configuration from `pat_in`, `len_in`, `overlap_in`.
- `pat_in` input, `MAX_LEN` bits: pattern. `pat_in[len-1]` is the first bit received; `pat_in[0]` is the last.
- `len_in` input, `LEN_W` bits: pattern length, legal range 1..`MAX_LEN`.
- `overlap_in` input, 1 bit: 1 selects overlapping detection; 0 selects non-overlapping.
- `inp` input, 1 bit: serial data bit.
- `inp_valid` input, 1 bit: qualifies `inp`; bits are sampled only when high.
- `result` output, 1 bit: one-cycle match pulse.
- `match_count` output, `CNT_W` bits: saturating match count.
- `cfg_err` output, 1 bit: one-cycle pulse when a load is rejected.

## Operation
- State:
  - history shift register `hist[MAX_LEN-1:0]`, newest bit in `[0]`
  - fill counter `fill`, saturating at `MAX_LEN`
  - config registers `pat`, `len`, `ovl`
  - `result`, `match_count`, `cfg_err`
- Reset values:
  - `hist`=0, `fill`=0
  - `pat`=`'b101` (zero-extended), `len`=3, `ovl`=1
  - `result`=0, `match_count`=0, `cfg_err`=0
- Sample cycle (`inp_valid`=1, `pat_load`=0):
  - `hist_n` = {`hist[MAX_LEN-2:0]`, `inp`}
  - `fill_n` = min(`fill`+1, `MAX_LEN`)
  - Match when `fill_n` >= `len` and `hist_n[len-1:0]` == `pat[len-1:0]`; bits above `len` are masked.
  - On match: `result`<=1 and `match_count` increments, saturating at all-ones.
  - Non-overlap mode (`ovl`=0): on match, `fill`<=0, so bits of a completed match cannot start the next match.
  - Overlap mode (`ovl`=1): `fill` continues to accumulate.
- Idle cycle (`inp_valid`=0): `hist` and `fill` hold; `result`<=0.
- Load (`pat_load`=1):
  - `len_in` in 1..`MAX_LEN`: latch `pat`/`len`/`ovl`; clear `hist` and `fill`; `result`<=0. `match_count` is not cleared.
  - `len_in`=0 or `len_in`>`MAX_LEN`: keep the old config, clear nothing, pulse `cfg_err` for one cycle.
  - In both cases `inp` is ignored that cycle, even when `inp_valid`=1.

## Timing
- Latency:
  - The bit completing a match is sampled at edge k.
  - `result` is high from edge k to edge k+1 (one cycle).
  - `match_count` reflects the new value after edge k.
- Back-to-back matches on consecutive samples produce consecutive `result` cycles with no forced gap.
- Reset is asserted asynchronously, including mid-stream, and takes effect immediately. The first sample after reset deassertion counts as bit 1.
- `cfg_err` is high for the single cycle after the rejected load edge.

## Configuration
- Macro `SEQ_DET_COUNT_EN`.
- Defined: `match_count` counter implemented as described.
- Undefined: no counter flops; `match_count` is tied to 0; `result` behaviour is unchanged.

## Test plan
- Reset defaults (101, overlap); stream 0,1,0,1,0,1,1 with `inp_valid`=1 -> `result` pulses after bits 4 and 6; `match_count`=2.
- Load `pat`=101, `len`=3, `overlap_in`=0; stream 1,0,1,0,1,0,1 -> pulses after bits 3 and 7 only. Overlap mode on the same stream -> pulses after bits 3, 5 and 7.
- Load `len`=8, `pat`=8'hA5; stream 1,0,1,0,0,1,0,1,0,0,1,0,1 -> pulses after bits 8 and 13 (overlap).
- Stream 1,0; assert `reset` asynchronously mid-cycle; release; stream 1 -> no pulse; `match_count`=0.
- Stream 1, `inp_valid`=0 for 3 cycles, then 0,1 -> one pulse after the final 1.
- `pat_load` with `len_in`=0 -> `cfg_err` one-cycle pulse; 101 still detected.
- With `CNT_W`=2 and `SEQ_DET_COUNT_EN` defined: 5 matches -> `match_count`=3 (saturated).
- With `SEQ_DET_COUNT_EN` undefined: `match_count` stays 0.

Source files
------------

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with overlap / non-overlap modes.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_det_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               overlap_in,
    input  logic               inp,
    input  logic               inp_valid,
    output logic               result,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_result;
    logic               r_cfg_err;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic               w_len_ok;
    logic               w_sample;

    assign w_hist_n = {r_hist[MAX_LEN-2:0], inp};
    assign w_fill_n = (r_fill >= LMAX) ? LMAX : r_fill + 1'b1;
    // Only the low len bits of history and pattern take part in the compare
    assign w_mask   = ~({MAX_LEN{1'b1}} << r_len);
    assign w_match  = (w_fill_n >= r_len) &&
                      (((w_hist_n ^ r_pat) & w_mask) == '0);
    assign w_len_ok = (len_in != '0) && (len_in <= LMAX);
    assign w_sample = inp_valid && !pat_load;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= MAX_LEN'(3'b101);
            r_len     <= LEN_W'(3);
            r_ovl     <= 1'b1;
            r_result  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= pat_load && !w_len_ok;
            r_result  <= w_sample && w_match;
            if (pat_load) begin
                if (w_len_ok) begin
                    r_pat  <= pat_in;
                    r_len  <= len_in;
                    r_ovl  <= overlap_in;
                    r_hist <= '0;
                    r_fill <= '0;
                end
            end else if (inp_valid) begin
                r_hist <= w_hist_n;
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_n;
            end
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_sample && w_match && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign match_count = r_count;
`else
    assign match_count = '0;
`endif

    assign result  = r_result;
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed, table-driven bench for seq_det_prog (MAX_LEN=8, CNT_W=2).
// Counter expectations follow SEQ_DET_COUNT_EN when it is defined.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clock;
    logic               reset;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               overlap_in;
    logic               inp;
    logic               inp_valid;
    logic               result;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .len_in      (len_in),
        .overlap_in  (overlap_in),
        .inp         (inp),
        .inp_valid   (inp_valid),
        .result      (result),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic               load;
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0]   len;
        logic               ovl;
        logic               valid;
        logic               b;
        logic               exp_res;
        logic               exp_err;
    } vec_t;

    vec_t vq[$];
    int checks;
    int failures;
    int exp_cnt;

    function automatic int cnt_exp();
`ifdef SEQ_DET_COUNT_EN
        return exp_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_bit(input logic b, input logic er);
        vq.push_back('{1'b0, '0, '0, 1'b0, 1'b1, b, er, 1'b0});
    endtask

    task automatic add_idle(input logic b);
        vq.push_back('{1'b0, '0, '0, 1'b0, 1'b0, b, 1'b0, 1'b0});
    endtask

    task automatic add_load(input logic [MAX_LEN-1:0] p,
                            input logic [LEN_W-1:0] l,
                            input logic o, input logic ee);
        vq.push_back('{1'b1, p, l, o, 1'b1, 1'b1, 1'b0, ee});
    endtask

    task automatic add_bits(input logic [15:0] bits, input int n,
                            input logic [15:0] exps);
        for (int i = n - 1; i >= 0; i--) add_bit(bits[i], exps[i]);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clock);
        pat_load   = v.load;
        pat_in     = v.pat;
        len_in     = v.len;
        overlap_in = v.ovl;
        inp_valid  = v.valid;
        inp        = v.b;
        @(posedge clock);
        #1;
        if (v.exp_res) exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
        chk({tag, " result"}, int'(result), int'(v.exp_res));
        chk({tag, " cfg_err"}, int'(cfg_err), int'(v.exp_err));
        chk({tag, " match_count"}, int'(match_count), cnt_exp());
    endtask

    initial begin
        vec_t v;
        checks     = 0;
        failures   = 0;
        exp_cnt    = 0;
        reset      = 1'b1;
        pat_load   = 1'b0;
        pat_in     = '0;
        len_in     = '0;
        overlap_in = 1'b0;
        inp        = 1'b0;
        inp_valid  = 1'b0;

        // defaults 101 overlap: pulses after bits 4 and 6
        add_bits(16'b0101011, 7, 16'b0001010);
        // non-overlap: pulses after bits 3 and 7; count saturates at 3
        add_load(8'b101, 4'd3, 1'b0, 1'b0);
        add_bits(16'b1010101, 7, 16'b0010001);
        // overlap on same stream: bits 3, 5, 7
        add_load(8'b101, 4'd3, 1'b1, 1'b0);
        add_bits(16'b1010101, 7, 16'b0010101);
        // full length pattern A5: bits 8 and 13
        add_load(8'hA5, 4'd8, 1'b1, 1'b0);
        add_bits(16'b1010010100101, 13, 16'b0000000100001);
        // idle cycles hold history
        add_load(8'b101, 4'd3, 1'b1, 1'b0);
        add_bit(1'b1, 1'b0);
        add_idle(1'b1);
        add_idle(1'b0);
        add_idle(1'b1);
        add_bits(16'b01, 2, 16'b01);
        // rejected loads keep config and history
        add_load(8'hFF, 4'd0, 1'b0, 1'b1);
        add_load(8'hFF, 4'd9, 1'b0, 1'b1);
        add_bits(16'b01, 2, 16'b01);
        add_bits(16'b101, 3, 16'b001);
        // single-bit pattern, non-overlap
        add_load(8'b1, 4'd1, 1'b0, 1'b0);
        add_bits(16'b110, 3, 16'b110);
        add_load(8'b101, 4'd3, 1'b1, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        chk("reset result", int'(result), 0);
        chk("reset match_count", int'(match_count), 0);
        chk("reset cfg_err", int'(cfg_err), 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

        // async reset mid-stream while a pulse is high
        v = '{1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        apply(v, "pre1");
        v.b = 1'b0;
        apply(v, "pre0");
        v.b = 1'b1;
        v.exp_res = 1'b1;
        apply(v, "pre1b");
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        chk("async result", int'(result), 0);
        chk("async match_count", int'(match_count), 0);
        @(negedge clock);
        inp_valid = 1'b0;
        pat_load  = 1'b0;
        reset     = 1'b0;
        v.b = 1'b1;
        v.exp_res = 1'b0;
        apply(v, "post1");
        v.b = 1'b0;
        apply(v, "post0");
        v.b = 1'b1;
        v.exp_res = 1'b1;
        apply(v, "post1b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
